// File: rtl/bus_mem_pkg.sv
// bus_mem_pkg
// Shared definitions for the bus-side memory interface: FSM state encoding,
// operation-type codes and the 16-bit datapath word type.
package bus_mem_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage : bus_mem_pkg

// File: rtl/bus_reg16.sv
// bus_reg16
// 16-bit register with synchronous active-high reset and load enable.
// Used for both MAR and MDR.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset (clears to 0)
//   ld_i   - load enable
//   d_i    - data to load
//   q_o    - register contents
module bus_reg16
    import bus_mem_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  ld_i,
    input  word_t d_i,
    output word_t q_o
);

    word_t data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : bus_reg16

// File: rtl/bus_mem_interface.sv
// bus_mem_interface
// Receiving end of the 16-bit datapath bus. Holds MAR/MDR and runs the SRAM
// read/write handshake with WAIT_STATES counted access cycles.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined     - an 8-bit cycle counter aborts an access after TIMEOUT
//                 ACCESS cycles (stalls included) and raises sticky Mem_Err.
//   not defined - stalls may last indefinitely; Mem_Err is constant 0.
//
// Ports:
//   Clk, Reset        - clock and synchronous active-high reset
//   Bus_In            - datapath bus value
//   LD_MAR, LD_MDR    - load MAR / MDR from Bus_In (ignored in ACCESS)
//   Mem_Req, Mem_RW   - start request and op type (1 = write), IDLE only
//   Mem_Wait          - SRAM stall, freezes the wait-state counter
//   Data_From_SRAM    - SRAM read data
//   ADDR, Data_To_SRAM- SRAM address (= MAR) and write data (= MDR)
//   CE_N, OE_N, WE_N  - registered active-low SRAM strobes
//   MAR_Out, MDR_Out  - register contents for the bus driver
//   Mem_Busy          - high in ACCESS
//   Mem_Ready         - one-cycle completion pulse (DONE)
//   Mem_Err           - timeout flag
//
// States:
//   IDLE   | waiting for Mem_Req; MAR/MDR loads honoured
//   ACCESS | strobes active, counting wait states
//   DONE   | Mem_Ready pulse, strobes off; MAR/MDR loads honoured
module bus_mem_interface
    import bus_mem_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Bus_In,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        Mem_Req,
    input  logic        Mem_RW,
    input  logic        Mem_Wait,
    input  logic [15:0] Data_From_SRAM,
    output logic [15:0] ADDR,
    output logic [15:0] Data_To_SRAM,
    output logic        CE_N,
    output logic        OE_N,
    output logic        WE_N,
    output logic [15:0] MAR_Out,
    output logic [15:0] MDR_Out,
    output logic        Mem_Busy,
    output logic        Mem_Ready,
    output logic        Mem_Err
);

    if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("bus_mem_interface: WAIT_STATES out of range 1..15");
    end
    if (TIMEOUT <= WAIT_STATES || TIMEOUT > 255) begin : g_bad_timeout
        $error("bus_mem_interface: TIMEOUT must exceed WAIT_STATES and be <= 255");
    end

    localparam logic [3:0] CNT_LAST = 4'(WAIT_STATES - 1);

    mem_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       op_q, op_d;
    logic       ce_n_q, oe_n_q, we_n_q;
    logic       busy_q, ready_q;
    logic       mdr_capture;
    logic       normal_done;

    word_t mar_q, mdr_q;
    logic  mar_ld, mdr_ld;
    word_t mdr_d;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tcnt_q, tcnt_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        mdr_capture = 1'b0;
        normal_done = 1'b0;
`ifdef MEM_TIMEOUT_EN
        tcnt_d      = tcnt_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (Mem_Req) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    op_d    = Mem_RW;
`ifdef MEM_TIMEOUT_EN
                    tcnt_d  = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ACCESS: begin
                if (!Mem_Wait) begin
                    if (cnt_q == CNT_LAST) begin
                        normal_done = 1'b1;
                        state_d     = DONE;
                        mdr_capture = (op_q == MEM_READ);
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                tcnt_d = tcnt_q + 8'd1;
                // A normal completion on the same edge takes priority.
                if (!normal_done && tcnt_q == TO_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes and status are registered from the next state so they switch
    // cleanly, aligned with the state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MEM_READ;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ce_n_q  <= (state_d != ACCESS);
            oe_n_q  <= !(state_d == ACCESS && op_d == MEM_READ);
            we_n_q  <= !(state_d == ACCESS && op_d == MEM_WRITE);
            busy_q  <= (state_d == ACCESS);
            ready_q <= (state_d == DONE);
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end
    assign Mem_Err = err_q;
`else
    assign Mem_Err = 1'b0;
`endif

    // Loads are blocked during ACCESS; MDR only takes the read capture there.
    assign mar_ld = LD_MAR && (state_q != ACCESS);
    assign mdr_ld = (LD_MDR && (state_q != ACCESS)) || mdr_capture;
    assign mdr_d  = mdr_capture ? Data_From_SRAM : Bus_In;

    bus_reg16 u_mar (
        .clk_i (Clk),
        .rst_i (Reset),
        .ld_i  (mar_ld),
        .d_i   (Bus_In),
        .q_o   (mar_q)
    );

    bus_reg16 u_mdr (
        .clk_i (Clk),
        .rst_i (Reset),
        .ld_i  (mdr_ld),
        .d_i   (mdr_d),
        .q_o   (mdr_q)
    );

    assign ADDR         = mar_q;
    assign Data_To_SRAM = mdr_q;
    assign MAR_Out      = mar_q;
    assign MDR_Out      = mdr_q;
    assign CE_N         = ce_n_q;
    assign OE_N         = oe_n_q;
    assign WE_N         = we_n_q;
    assign Mem_Busy     = busy_q;
    assign Mem_Ready    = ready_q;

endmodule : bus_mem_interface
